// File: rtl/add_pipe_pkg.sv
// rtl/add_pipe_pkg.sv - shared constants and payload sizing for the pipelined adder/subtractor
package add_pipe_pkg;

    localparam logic ADD_OP_ADD = 1'b0;
    localparam logic ADD_OP_SUB = 1'b1;

    localparam int SAT_WRAP  = 0;
    localparam int SAT_CLAMP = 1;

    // Payload is {sub, carry, ovf, data}; data is the only width-dependent field.
    function automatic int payload_width(input int width);
        return width + 3;
    endfunction

endpackage

// File: rtl/add_pipe_slice.sv
// rtl/add_pipe_slice.sv - one valid/ready register slice; empty slots are refilled so bubbles collapse
module add_pipe_slice #(
    parameter int C_W = 11
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_s_tvalid,
    output logic           o_s_tready,
    input  logic [C_W-1:0] i_s_tdata,
    output logic           o_m_tvalid,
    input  logic           i_m_tready,
    output logic [C_W-1:0] o_m_tdata
);

    logic           r_valid;
    logic [C_W-1:0] r_data;

    assign o_s_tready = !r_valid || i_m_tready;
    assign o_m_tvalid = r_valid;
    assign o_m_tdata  = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_s_tready) begin
            r_valid <= i_s_tvalid;
            // Data only moves with a real beat so an empty output keeps its last value.
            if (i_s_tvalid) begin
                r_data <= i_s_tdata;
            end
        end
    end

endmodule

// File: rtl/add_pipe.sv
// rtl/add_pipe.sv - pipelined unsigned add/sub with carry/borrow, overflow flag and optional saturation
module add_pipe
    import add_pipe_pkg::*;
#(
    parameter int C_WIDTH  = 8,
    parameter int C_STAGES = 2,
    parameter int C_SAT    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [C_WIDTH-1:0] in_a,
    input  logic [C_WIDTH-1:0] in_b,
    input  logic               in_sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [C_WIDTH-1:0] out_c,
    output logic               out_carry,
    output logic               out_ovf
);

    localparam int P_W = payload_width(C_WIDTH);

    typedef struct packed {
        logic               sub;
        logic               carry;
        logic               ovf;
        logic [C_WIDTH-1:0] data;
    } payload_t;

    logic [C_WIDTH:0] w_sum;
    payload_t         w_in_pl;
    payload_t         w_out_pl;
    logic [C_STAGES:0] w_valid;
    logic [C_STAGES:0] w_ready;
    logic [P_W-1:0]    w_data [C_STAGES+1];

    // The extra top bit is the carry on add and the borrow on subtract.
    always_comb begin
        w_sum = '0;
        if (in_sub == ADD_OP_SUB) begin
            w_sum = {1'b0, in_a} - {1'b0, in_b};
        end else begin
            w_sum = {1'b0, in_a} + {1'b0, in_b};
        end
    end

    always_comb begin
        w_in_pl       = '0;
        w_in_pl.sub   = in_sub;
        w_in_pl.carry = w_sum[C_WIDTH];
        w_in_pl.ovf   = w_sum[C_WIDTH];
        w_in_pl.data  = w_sum[C_WIDTH-1:0];
    end

    assign w_valid[0]        = in_valid;
    assign w_data[0]         = P_W'(w_in_pl);
    assign in_ready          = w_ready[0];
    assign w_ready[C_STAGES] = out_ready;

    for (genvar g = 0; g < C_STAGES; g++) begin : g_stage
        add_pipe_slice #(
            .C_W(P_W)
        ) u_slice (
            .clk        (clk),
            .rst        (rst),
            .i_s_tvalid (w_valid[g]),
            .o_s_tready (w_ready[g]),
            .i_s_tdata  (w_data[g]),
            .o_m_tvalid (w_valid[g+1]),
            .i_m_tready (w_ready[g+1]),
            .o_m_tdata  (w_data[g+1])
        );
    end

    assign w_out_pl  = payload_t'(w_data[C_STAGES]);
    assign out_valid = w_valid[C_STAGES];
    assign out_carry = w_out_pl.carry;
    assign out_ovf   = w_out_pl.ovf;

    // Clamp toward the bound that was crossed: all ones on add, zero on subtract.
    always_comb begin
        out_c = w_out_pl.data;
        if (C_SAT == SAT_CLAMP && w_out_pl.ovf) begin
            out_c = w_out_pl.sub ? '0 : '1;
        end
    end

endmodule

// File: tb/tb_add_pipe.sv
// tb/tb_add_pipe.sv - randomized and directed checks of add_pipe in wrap and saturate modes
module tb_add_pipe;

    localparam int W    = 8;
    localparam int ST   = 2;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_sub = 1'b0;
    logic         out_ready = 1'b1;

    logic         in_ready_w, in_ready_s;
    logic         out_valid_w, out_valid_s;
    logic [W-1:0] c_w, c_s;
    logic         carry_w, carry_s, ovf_w, ovf_s;

    always #5 clk = ~clk;

    add_pipe #(.C_WIDTH(W), .C_STAGES(ST), .C_SAT(0)) u_dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(out_valid_w), .out_ready(out_ready),
        .out_c(c_w), .out_carry(carry_w), .out_ovf(ovf_w)
    );

    add_pipe #(.C_WIDTH(W), .C_STAGES(ST), .C_SAT(1)) u_dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .out_c(c_s), .out_carry(carry_s), .out_ovf(ovf_s)
    );

    typedef struct {
        int a;
        int b;
        bit sub;
    } beat_t;

    beat_t exp_q[$];
    int    n_err = 0;
    int    n_chk = 0;
    int    n_out = 0;
    int    n_acc = 0;
    int    run = 0;
    int    max_run = 0;
    int    last_w = 0;
    int    last_s = 0;
    int    last_carry = 0;
    int    last_ovf = 0;
    bit    done = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: record accepted beats, check every output transfer against plain arithmetic.
    initial begin
        bit prev_stall = 0;
        int prev_c = 0;
        int prev_carry = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                prev_stall = 0;
                run = 0;
            end else begin
                if (in_valid && in_ready_w) begin
                    beat_t bt;
                    bt.a = int'(in_a);
                    bt.b = int'(in_b);
                    bt.sub = in_sub;
                    exp_q.push_back(bt);
                    n_acc++;
                end
                if (prev_stall) begin
                    check_eq("stall_valid", int'(out_valid_w), 1);
                    check_eq("stall_c", int'(c_w), prev_c);
                    check_eq("stall_carry", int'(carry_w), prev_carry);
                end
                run = out_valid_w ? run + 1 : 0;
                if (run > max_run) max_run = run;
                if (out_valid_w && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("spurious_beat", exp_q.size(), 1);
                    end else begin
                        beat_t bt;
                        int full, wrap, sat, cy;
                        bt = exp_q.pop_front();
                        full = bt.sub ? bt.a - bt.b : bt.a + bt.b;
                        cy = bt.sub ? int'(bt.a < bt.b) : int'(full > MAXV);
                        wrap = full & MAXV;
                        sat = cy != 0 ? (bt.sub ? 0 : MAXV) : wrap;
                        check_eq("c_wrap", int'(c_w), wrap);
                        check_eq("c_sat", int'(c_s), sat);
                        check_eq("carry", int'(carry_w), cy);
                        check_eq("ovf", int'(ovf_w), cy);
                        check_eq("carry_sat", int'(carry_s), cy);
                        check_eq("valid_sat", int'(out_valid_s), 1);
                        n_out++;
                        last_w = int'(c_w);
                        last_s = int'(c_s);
                        last_carry = int'(carry_w);
                        last_ovf = int'(ovf_w);
                    end
                end
                prev_stall = out_valid_w && !out_ready;
                prev_c = int'(c_w);
                prev_carry = int'(carry_w);
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_sub = s;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready_w) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        check_eq("send_timeout", int'(in_ready_w), 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !out_valid_w) return;
        end
        check_eq("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        int k;
        int n0;
        int a0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", int'(out_valid_w), 0);
        check_eq("rst_out_c", int'(c_w), 0);
        check_eq("rst_carry", int'(carry_w), 0);
        check_eq("rst_ovf", int'(ovf_w), 0);
        check_eq("rst_out_c_sat", int'(c_s), 0);
        check_eq("rst_in_ready", int'(in_ready_w), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(8'hFF, 8'hFF, 1'b0);
        drain();
        check_eq("ffff_wrap", last_w, 'hFE);
        check_eq("ffff_sat", last_s, 'hFF);
        check_eq("ffff_carry", last_carry, 1);
        check_eq("ffff_ovf", last_ovf, 1);

        send(8'h05, 8'h07, 1'b1);
        drain();
        check_eq("sub_wrap", last_w, 'hFE);
        check_eq("sub_sat", last_s, 'h00);
        check_eq("sub_borrow", last_carry, 1);

        in_valid = 1'b1;
        in_a = 8'h00;
        in_b = 8'h01;
        in_sub = 1'b0;
        @(negedge clk);
        check_eq("lat_in_ready", int'(in_ready_w), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            k++;
            if (out_valid_w) break;
        end
        check_eq("latency", k, ST);
        drain();
        check_eq("inc_c", last_w, 1);
        check_eq("inc_carry", last_carry, 0);
        check_eq("inc_ovf", last_ovf, 0);

        max_run = 0;
        n0 = n_out;
        for (int i = 0; i < 16; i++) begin
            send(W'($urandom_range(0, MAXV)), W'($urandom_range(0, MAXV)), 1'($urandom_range(0, 1)));
        end
        drain();
        check_eq("stream_count", n_out - n0, 16);
        check_eq("stream_run", max_run, 16);

        n0 = n_out;
        a0 = n_acc;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(W'($urandom_range(0, MAXV)), W'($urandom_range(0, MAXV)), 1'($urandom_range(0, 1)));
                end
            end
            begin
                repeat (6) @(negedge clk);
                check_eq("full_in_ready", int'(in_ready_w), 0);
                check_eq("full_accepted", n_acc - a0, ST);
                check_eq("full_out_valid", int'(out_valid_w), 1);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check_eq("stall_count", n_out - n0, 8);

        done = 0;
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    send(W'($urandom_range(0, MAXV)), W'($urandom_range(0, MAXV)), 1'($urandom_range(0, 1)));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check_eq("mix_count", n_out - n0, 40);

        out_ready = 1'b0;
        send(8'h11, 8'h22, 1'b0);
        send(8'h33, 8'h44, 1'b0);
        rst = 1'b1;
        in_valid = 1'b1;
        in_a = 8'hAA;
        in_b = 8'h55;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        check_eq("midrst_out_valid", int'(out_valid_w), 0);
        check_eq("midrst_in_ready", int'(in_ready_w), 1);
        out_ready = 1'b1;
        n0 = n_out;
        repeat (5) @(posedge clk);
        #1;
        check_eq("midrst_no_stale", n_out - n0, 0);
        send(8'h10, 8'h20, 1'b0);
        drain();
        check_eq("midrst_fresh", last_w, 'h30);
        check_eq("midrst_count", n_out - n0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
